// File: rtl/dut_access_master.sv
// -----------------------------------------------------------------------------
// dut_access_master
//
// Bus initiator for the register-mapped OR-accelerator slave. It takes {a,b}
// operand pairs from a valid/ready stream and writes A, then B, into the slave.
// It waits for a Y result, pops it, and returns it on a valid/ready result
// stream. Before each access it polls the matching slave status bit.
//
// Slave map: rd 0 = A-not-full[0], 1 = B-not-full[0], 2 = Y-not-empty[0],
//            3 = Y data (read strobe pops Y); wr 4 = A, 5 = B.
//
// Ports
//   CLK, RST_N        clock (posedge), synchronous active-low reset
//   op_valid/op_ready operand stream handshake; op_a, op_b operands
//   res_valid/ready   result stream handshake; res_data (A|B, 0x00 on error),
//                     res_err (status poll timed out)
//   m_write_*         slave write port (address, data, strobe, ready)
//   m_read_*          slave read port (address, strobe, data, ready); the
//                     slave drives read data combinationally from the address
//   txn_count         results delivered, wraps at 2^CNT_W
//
// Parameters
//   POLL_TIMEOUT      the poll aborts after this many consecutive samples with
//                     status bit 0; 0 disables the abort. Set it above 256,
//                     because the slave produces Y only once per 256-cycle
//                     counter wrap.
//   CNT_W             width of txn_count
// -----------------------------------------------------------------------------
module dut_access_master #(
    parameter int POLL_TIMEOUT = 1023,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_err,
    output logic [2:0]       m_write_address,
    output logic [7:0]       m_write_data,
    output logic             m_write_en,
    input  logic             m_write_rdy,
    output logic [2:0]       m_read_address,
    output logic             m_read_en,
    input  logic [7:0]       m_read_data,
    input  logic             m_read_rdy,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RESP
    } state_t;

    localparam int PCNT_W = (POLL_TIMEOUT > 2) ? $clog2(POLL_TIMEOUT) : 1;
    localparam logic [PCNT_W-1:0] POLL_LAST =
        PCNT_W'((POLL_TIMEOUT > 0) ? POLL_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (POLL_TIMEOUT != 0);

    state_t            state;
    state_t            poll_next;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [PCNT_W-1:0] poll_cnt;

    // op_ready is held low while RST_N is asserted, even in the cycle before
    // the reset edge moves the FSM back to IDLE.
    assign op_ready = RST_N && (state == IDLE);

    // Bus decode. The strobes follow the slave ready signals directly, so
    // each access produces exactly one strobe: at the edge where ready is
    // high, the FSM leaves the access state. The strobes are also gated by
    // RST_N, so no access is started in a cycle that is being reset.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        m_write_address = 3'd0;
        m_write_data    = 8'h00;
        m_write_en      = 1'b0;
        m_read_address  = 3'd0;
        m_read_en       = 1'b0;
        poll_next       = IDLE;
        case (state)
            POLL_A: begin
                m_read_address = 3'd0;
                poll_next      = WR_A;
            end
            POLL_B: begin
                m_read_address = 3'd1;
                poll_next      = WR_B;
            end
            POLL_Y: begin
                m_read_address = 3'd2;
                poll_next      = RD_Y;
            end
            WR_A: begin
                m_write_address = 3'd4;
                m_write_data    = a_q;
                m_write_en      = m_write_rdy && RST_N;
            end
            WR_B: begin
                m_write_address = 3'd5;
                m_write_data    = b_q;
                m_write_en      = m_write_rdy && RST_N;
            end
            RD_Y: begin
                m_read_address = 3'd3;
                m_read_en      = m_read_rdy && RST_N;
            end
            default: ;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments, so every
    // register samples values from before the edge, whatever the statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            poll_cnt  <= '0;
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        state <= POLL_A;
                    end
                end
                // Status polls only sample; they never strobe, because a
                // strobe at address 0 would dequeue A.
                POLL_A, POLL_B, POLL_Y: begin
                    if (m_read_data[0]) begin
                        poll_cnt <= '0;
                        state    <= poll_next;
                    end else if (TIMEOUT_EN && poll_cnt == POLL_LAST) begin
                        // Abort. Anything already written stays in the slave.
                        poll_cnt  <= '0;
                        res_valid <= 1'b1;
                        res_data  <= 8'h00;
                        res_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        poll_cnt <= poll_cnt + PCNT_W'(1);
                    end
                end
                WR_A: if (m_write_rdy) state <= POLL_B;
                WR_B: if (m_write_rdy) state <= POLL_Y;
                RD_Y: begin
                    if (m_read_rdy) begin
                        res_data  <= m_read_data;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dut_access_master.sv
// -----------------------------------------------------------------------------
// tb_dut_access_master
//
// Bench for dut_access_master. The main instance talks to a behavioural model
// of the OR-accelerator slave: 4-deep A/B/Y FIFOs, and Y = A|B computed when a
// free-running 8-bit counter wraps. A second instance, with POLL_TIMEOUT = 8,
// talks to a stub slave whose Y status is under bench control. Results are
// checked against a scoreboard queue that is filled when operands are sent.
// -----------------------------------------------------------------------------
module tb_dut_access_master;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    // ---------------- main DUT + behavioural slave ----------------
    logic        op_valid, op_ready, res_valid, res_ready, res_err;
    logic [7:0]  op_a, op_b, res_data;
    logic [2:0]  m_write_address, m_read_address;
    logic [7:0]  m_write_data, sl_rd_data;
    logic        m_write_en, m_read_en, sl_wr_rdy, sl_rd_rdy;
    logic [15:0] txn_count;

    dut_access_master dut (
        .CLK(clk), .RST_N(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .m_write_address(m_write_address), .m_write_data(m_write_data),
        .m_write_en(m_write_en), .m_write_rdy(sl_wr_rdy),
        .m_read_address(m_read_address), .m_read_en(m_read_en),
        .m_read_data(sl_rd_data), .m_read_rdy(sl_rd_rdy),
        .txn_count(txn_count)
    );

    logic [7:0] a_mem [4];
    logic [7:0] b_mem [4];
    logic [7:0] y_mem [4];
    logic [1:0] a_wp, a_rp, b_wp, b_rp, y_wp, y_rp;
    int         a_n, b_n, y_n;
    logic [7:0] wrap_cnt;

    wire a_push  = m_write_en && m_write_address == 3'd4 && a_n < 4;
    wire b_push  = m_write_en && m_write_address == 3'd5 && b_n < 4;
    wire compute = wrap_cnt == 8'hFF && a_n > 0 && b_n > 0 && y_n < 4;
    wire y_pop   = m_read_en && m_read_address == 3'd3 && y_n > 0;

    assign sl_rd_data = (m_read_address == 3'd0) ? {7'd0, a_n < 4} :
                        (m_read_address == 3'd1) ? {7'd0, b_n < 4} :
                        (m_read_address == 3'd2) ? {7'd0, y_n > 0} :
                        (m_read_address == 3'd3) ? y_mem[y_rp] : 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            a_wp <= '0; a_rp <= '0; b_wp <= '0; b_rp <= '0; y_wp <= '0; y_rp <= '0;
            a_n <= 0; b_n <= 0; y_n <= 0; wrap_cnt <= 8'h00;
        end else begin
            wrap_cnt <= wrap_cnt + 8'd1;
            if (a_push) begin a_mem[a_wp] <= m_write_data; a_wp <= a_wp + 2'd1; end
            if (b_push) begin b_mem[b_wp] <= m_write_data; b_wp <= b_wp + 2'd1; end
            if (compute) begin
                y_mem[y_wp] <= a_mem[a_rp] | b_mem[b_rp];
                y_wp <= y_wp + 2'd1; a_rp <= a_rp + 2'd1; b_rp <= b_rp + 2'd1;
            end
            if (y_pop) y_rp <= y_rp + 2'd1;
            a_n <= a_n + int'(a_push) - int'(compute);
            b_n <= b_n + int'(b_push) - int'(compute);
            y_n <= y_n + int'(compute) - int'(y_pop);
        end
    end

    // ---------------- timeout DUT + stub slave ----------------
    logic        to_op_valid, to_op_ready, to_res_valid, to_res_ready, to_res_err;
    logic [7:0]  to_res_data, to_wr_data, to_rd_data;
    logic [2:0]  to_wr_addr, to_rd_addr;
    logic        to_wr_en, to_rd_en, stub_y_ok;
    logic [15:0] to_txn_count;

    dut_access_master #(.POLL_TIMEOUT(8)) dut_to (
        .CLK(clk), .RST_N(rst_n),
        .op_valid(to_op_valid), .op_ready(to_op_ready), .op_a(8'h12), .op_b(8'h34),
        .res_valid(to_res_valid), .res_ready(to_res_ready), .res_data(to_res_data),
        .res_err(to_res_err),
        .m_write_address(to_wr_addr), .m_write_data(to_wr_data),
        .m_write_en(to_wr_en), .m_write_rdy(1'b1),
        .m_read_address(to_rd_addr), .m_read_en(to_rd_en),
        .m_read_data(to_rd_data), .m_read_rdy(1'b1),
        .txn_count(to_txn_count)
    );

    assign to_rd_data = (to_rd_addr == 3'd0 || to_rd_addr == 3'd1) ? 8'h01 :
                        (to_rd_addr == 3'd2) ? {7'd0, stub_y_ok} :
                        (to_rd_addr == 3'd3) ? 8'h5A : 8'h00;

    // ---------------- strobe counters ----------------
    int wr4_cnt = 0, wr5_cnt = 0, pop_cnt = 0, to_ysamp = 0, to_pop = 0;
    always @(posedge clk) begin
        if (m_write_en && m_write_address == 3'd4) wr4_cnt <= wr4_cnt + 1;
        if (m_write_en && m_write_address == 3'd5) wr5_cnt <= wr5_cnt + 1;
        if (m_read_en) pop_cnt <= pop_cnt + 1;
        if (to_rd_addr == 3'd2) to_ysamp <= to_ysamp + 1;
        if (to_rd_en) to_pop <= to_pop + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus-protocol invariants, checked every cycle on both instances.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("rd_en_addr", 32'(m_read_en && m_read_address != 3'd3), 0);
            check("rd_wr_excl", 32'(m_read_en && m_write_en), 0);
            check("to_rd_en_addr", 32'(to_rd_en && to_rd_addr != 3'd3), 0);
        end
    end

    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        op_a = a; op_b = b; op_valid = 1'b1;
        while (op_ready !== 1'b1 && n < 50) begin step(); n++; end
        check("op_ready_wait", 32'(op_ready), 1);
        step();
        op_valid = 1'b0;
        sb.push_back('{err: 1'b0, data: a | b});
    endtask

    task automatic wait_result(input string tag, input int budget, output int lat);
        res_t exp;
        lat = 0;
        while (res_valid !== 1'b1 && lat < budget) begin step(); lat++; end
        check({tag, "_valid"}, 32'(res_valid), 1);
        if (res_valid === 1'b1) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check({tag, "_data"}, 32'(res_data), 32'(exp.data));
                check({tag, "_err"}, 32'(res_err), 32'(exp.err));
            end
            if (res_ready === 1'b1) step();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, n, s4, s5, sp;
        logic [7:0] av [4];
        logic [7:0] bv [4];
        av = '{8'h01, 8'h10, 8'h00, 8'h80};
        bv = '{8'h02, 8'h20, 8'h00, 8'h7F};

        rst_n = 1'b0; op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00; res_ready = 1'b1;
        sl_wr_rdy = 1'b1; sl_rd_rdy = 1'b1;
        to_op_valid = 1'b0; to_res_ready = 1'b1; stub_y_ok = 1'b1;
        step(); step();

        // Reset state
        check("rst_op_ready", 32'(op_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_err", 32'(res_err), 0);
        check("rst_txn", 32'(txn_count), 0);
        check("rst_bus", {m_write_address, m_read_address, m_write_data, m_write_en, m_read_en}, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_op_ready", 32'(op_ready), 1);

        // Single op through the real slave, bounded latency
        send_op(8'h0F, 8'hF0);
        wait_result("first", 300, lat);
        check("first_lat_le_262", 32'(lat <= 262), 1);
        check("first_lat_ge_7", 32'(lat >= 7), 1);
        check("txn_1", 32'(txn_count), 1);

        // Four back-to-back ops, results in order
        for (int i = 0; i < 4; i++) begin
            send_op(av[i], bv[i]);
            wait_result("b2b", 300, lat);
        end
        check("txn_5", 32'(txn_count), 5);

        // Consumer stall in RESP
        res_ready = 1'b0;
        send_op(8'h33, 8'h44);
        wait_result("stall", 300, lat);
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_valid", 32'(res_valid), 1);
            check("stall_data", 32'(res_data), 32'h77);
            check("stall_op_ready", 32'(op_ready), 0);
            check("stall_strobes", 32'(m_write_en | m_read_en), 0);
        end
        res_ready = 1'b1;
        step();
        check("stall_done_valid", 32'(res_valid), 0);
        check("txn_6", 32'(txn_count), 6);

        // Write ready held low in WR_A
        s4 = wr4_cnt; s5 = wr5_cnt; sp = pop_cnt;
        sl_wr_rdy = 1'b0;
        send_op(8'hA0, 8'h05);
        n = 0;
        while (m_write_address !== 3'd4 && n < 20) begin step(); n++; end
        check("wra_reached", 32'(m_write_address), 4);
        for (int i = 0; i < 5; i++) begin
            check("wra_en_low", 32'(m_write_en), 0);
            step();
        end
        sl_wr_rdy = 1'b1;
        wait_result("wrrdy", 300, lat);
        check("wrrdy_one_a", 32'(wr4_cnt - s4), 1);
        check("wrrdy_one_b", 32'(wr5_cnt - s5), 1);
        check("wrrdy_one_pop", 32'(pop_cnt - sp), 1);

        // Stub slave: minimum latency with all statuses already 1
        to_op_valid = 1'b1;
        step();
        to_op_valid = 1'b0;
        lat = 0;
        while (to_res_valid !== 1'b1 && lat < 40) begin step(); lat++; end
        check("stub_lat", 32'(lat), 6);
        check("stub_data", 32'(to_res_data), 32'h5A);
        check("stub_err", 32'(to_res_err), 0);
        step();

        // Stub slave: Y status stuck at 0, POLL_TIMEOUT = 8
        stub_y_ok = 1'b0;
        s4 = to_ysamp; sp = to_pop;
        to_op_valid = 1'b1;
        step();
        to_op_valid = 1'b0;
        lat = 0;
        while (to_res_valid !== 1'b1 && lat < 40) begin step(); lat++; end
        check("to_valid", 32'(to_res_valid), 1);
        check("to_lat", 32'(lat), 12);
        check("to_err", 32'(to_res_err), 1);
        check("to_data", 32'(to_res_data), 0);
        check("to_y_samples", 32'(to_ysamp - s4), 8);
        check("to_no_pop", 32'(to_pop - sp), 0);
        step();
        check("to_txn", 32'(to_txn_count), 2);

        // Reset during WR_B
        s5 = wr5_cnt;
        send_op(8'h11, 8'h22);
        n = 0;
        while (m_write_address !== 3'd5 && n < 20) begin step(); n++; end
        check("wrb_reached", 32'(m_write_address), 5);
        rst_n = 1'b0;
        #1;
        check("rst_wrb_en", 32'(m_write_en), 0);
        check("rst_wrb_op_ready", 32'(op_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        sb.delete();
        check("rst_wrb_strobes", 32'(m_write_en | m_read_en), 0);
        check("rst_wrb_op_ready1", 32'(op_ready), 1);
        check("rst_wrb_txn", 32'(txn_count), 0);
        check("rst_wrb_res_valid", 32'(res_valid), 0);
        check("rst_wrb_no_b", 32'(wr5_cnt - s5), 0);

        // Normal operation after the mid-op reset
        send_op(8'h0F, 8'h30);
        wait_result("recover", 300, lat);
        check("recover_txn", 32'(txn_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
